// File: rtl/bus_sizer.sv
// -----------------------------------------------------------------------------
// bus_sizer
//   Splits one internal transfer (start lane ba, byte count cnt) into a series
//   of external bus cycles sized to the external memory width. Each cycle is
//   one ADDR cycle followed by CYC cycles that last until ack.
//
//   Optional feature macro: BUS_ACK_TIMEOUT_EN
//     defined   -> an 8-bit ack watchdog ends a stuck CYC with done+err
//     undefined -> CYC waits for ack indefinitely
//
// Ports
//   sys_clk  in   clock, rising edge
//   reset    in   synchronous active-high reset
//   req      in   transfer request, accepted only while idle
//   reads    in   1 = read (external to internal), 0 = write
//   ba       in   start byte lane
//   cnt      in   byte count (legal 1..NB-ba)
//   mws      in   external width code 0..3 = 8/16/32/64 bits (clamped to IW)
//   ack      in   external cycle complete
//   idle     out  ready for req
//   aen      out  address drive enable (ADDR and CYC)
//   xa       out  external byte address, aligned to memory width
//   den      out  per-lane data enables of the current cycle
//   dmux     out  lane steering offset (xa during a cycle, else 0)
//   dren     out  read data register load pulse
//   done     out  end-of-transfer pulse
//   err      out  qualifies done for illegal or timed-out transfers
// -----------------------------------------------------------------------------
module bus_sizer #(
    parameter  int IW = 64,
    localparam int NB = IW / 8,
    localparam int AW = $clog2(NB)
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          req,
    input  logic          reads,
    input  logic [AW-1:0] ba,
    input  logic [AW:0]   cnt,
    input  logic [1:0]    mws,
    input  logic          ack,
    output logic          idle,
    output logic          aen,
    output logic [AW-1:0] xa,
    output logic [NB-1:0] den,
    output logic [AW-1:0] dmux,
    output logic          dren,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_CYC  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          reads_q, reads_d;
    logic [AW-1:0] ba_q,    ba_d;
    logic [AW:0]   end_q,   end_d;   // ba + cnt, one past the last lane
    logic [AW:0]   mw_q,    mw_d;    // memory width in bytes
    logic [AW:0]   xa_q,    xa_d;    // one extra bit so the advance never wraps
    logic          err_q,   err_d;
`ifdef BUS_ACK_TIMEOUT_EN
    logic [7:0]    tmo_q,   tmo_d;
`endif

    logic [AW+1:0] sum_s;
    logic          illegal_s;
    logic [AW:0]   mw_new_s;
    logic [AW:0]   xa_start_s;
    logic [AW:0]   xa_nxt_s;
    logic [AW:0]   lo_s;
    logic [AW:0]   hi_s;
    logic          aen_s;
    logic [NB-1:0] den_s;

    // Request decode: legality check, width clamp and aligned start address.
    always_comb begin
        sum_s     = {2'b00, ba} + {1'b0, cnt};
        illegal_s = (cnt == '0) || (sum_s > (AW+2)'(NB));
        if (int'(mws) > AW) begin
            mw_new_s = (AW+1)'(NB);
        end else begin
            mw_new_s = (AW+1)'(1) << mws;
        end
        // floor(ba/MW)*MW: MW is a power of two, so clear the low bits.
        xa_start_s = {1'b0, ba} & ~(mw_new_s - (AW+1)'(1));
    end

    // Lane window of the current cycle: max(ba,xa) <= lane < min(end, xa+MW).
    always_comb begin
        aen_s    = (state_q == S_ADDR) || (state_q == S_CYC);
        xa_nxt_s = xa_q + mw_q;
        lo_s     = ({1'b0, ba_q} > xa_q) ? {1'b0, ba_q} : xa_q;
        hi_s     = (end_q < xa_nxt_s) ? end_q : xa_nxt_s;
        den_s    = '0;
        for (int i = 0; i < NB; i++) begin
            den_s[i] = aen_s && ((AW+1)'(i) >= lo_s) && ((AW+1)'(i) < hi_s);
        end
    end

    // Next-state logic of the transfer sequencer.
    always_comb begin
        state_d = state_q;
        reads_d = reads_q;
        ba_d    = ba_q;
        end_d   = end_q;
        mw_d    = mw_q;
        xa_d    = xa_q;
        err_d   = err_q;
`ifdef BUS_ACK_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    reads_d = reads;
                    ba_d    = ba;
                    end_d   = sum_s[AW:0];
                    mw_d    = mw_new_s;
                    xa_d    = xa_start_s;
                    if (illegal_s) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ADDR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
`ifdef BUS_ACK_TIMEOUT_EN
                tmo_d   = 8'd0;
`endif
                state_d = S_CYC;
            end
            S_CYC: begin
                if (ack) begin
                    if (xa_nxt_s >= end_q) begin
                        state_d = S_DONE;
                    end else begin
                        xa_d    = xa_nxt_s;
                        state_d = S_ADDR;
                    end
                end else begin
`ifdef BUS_ACK_TIMEOUT_EN
                    // The 255th ack-less CYC cycle is the last one.
                    if (tmo_q == 8'd254) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        tmo_d   = tmo_q + 8'd1;
                        state_d = S_CYC;
                    end
`else
                    state_d = S_CYC;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and transfer context registers.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            reads_q <= 1'b0;
            ba_q    <= '0;
            end_q   <= '0;
            mw_q    <= '0;
            xa_q    <= '0;
            err_q   <= 1'b0;
`ifdef BUS_ACK_TIMEOUT_EN
            tmo_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            reads_q <= reads_d;
            ba_q    <= ba_d;
            end_q   <= end_d;
            mw_q    <= mw_d;
            xa_q    <= xa_d;
            err_q   <= err_d;
`ifdef BUS_ACK_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Output decode; everything except dren depends only on registered state.
    always_comb begin
        idle = (state_q == S_IDLE);
        aen  = aen_s;
        den  = den_s;
        done = (state_q == S_DONE);
        err  = (state_q == S_DONE) && err_q;
        dren = (state_q == S_CYC) && ack && reads_q;
        if (aen_s) begin
            xa   = xa_q[AW-1:0];
            dmux = xa_q[AW-1:0];
        end else begin
            xa   = '0;
            dmux = '0;
        end
    end

endmodule

// File: tb/tb_bus_sizer.sv
module tb_bus_sizer;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       req;
    logic       reads;
    logic [2:0] ba;
    logic [3:0] cnt;
    logic [1:0] mws;
    logic       ack;
    logic       idle;
    logic       aen;
    logic [2:0] xa;
    logic [7:0] den;
    logic [2:0] dmux;
    logic       dren;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        bit         is_done;
        logic [2:0] xa;
        logic [7:0] den;
        logic       dren;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    bus_sizer #(.IW(64)) dut (
        .sys_clk(sys_clk), .reset(reset), .req(req), .reads(reads),
        .ba(ba), .cnt(cnt), .mws(mws), .ack(ack),
        .idle(idle), .aen(aen), .xa(xa), .den(den), .dmux(dmux),
        .dren(dren), .done(done), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_cyc(input logic [2:0] x, input logic [7:0] d, input logic r);
        exp_t e;
        e.is_done = 1'b0; e.xa = x; e.den = d; e.dren = r; e.err = 1'b0; e.cyc = 0;
        sb.push_back(e);
    endtask

    task automatic push_done(input logic e_err, input int at);
        exp_t e;
        e.is_done = 1'b1; e.xa = '0; e.den = '0; e.dren = 1'b0; e.err = e_err; e.cyc = at;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per completed external cycle and per done.
    always @(negedge sys_clk) begin
        exp_t e;
        if (aen === 1'b1 && ack === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_cycle", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("cycle_slot", {31'd0, e.is_done}, 32'd0);
                chk("xa", {29'd0, xa}, {29'd0, e.xa});
                chk("den", {24'd0, den}, {24'd0, e.den});
                chk("dmux", {29'd0, dmux}, {29'd0, e.xa});
                chk("dren", {31'd0, dren}, {31'd0, e.dren});
            end
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_slot", {31'd0, e.is_done}, 32'd1);
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("done_cycle", cyc, e.cyc);
            end
        end
        if (err === 1'b1 && done !== 1'b1) begin
            chk("err_without_done", 32'd1, 32'd0);
        end
    end

    // Legal transfer; w holds a 2-bit ack wait count per external cycle.
    task automatic xfer(input logic rd, input logic [2:0] b, input logic [3:0] c,
                        input logic [1:0] m, input int ncyc, input int w, input bit noise);
        int t0;
        int tot;
        chk("idle_before_req", {31'd0, idle}, 32'd1);
        req = 1'b1; reads = rd; ba = b; cnt = c; mws = m;
        @(posedge sys_clk); #1;
        t0 = cyc;
        tot = 0;
        for (int i = 0; i < ncyc; i++) tot += 2 + ((w >> (2 * i)) & 3);
        push_done(1'b0, t0 + tot);
        if (noise) begin
            reads = ~rd; ba = ~b; cnt = 4'd1; mws = ~m;
        end else begin
            req = 1'b0;
        end
        for (int i = 0; i < ncyc; i++) begin
            @(posedge sys_clk); #1;
            repeat ((w >> (2 * i)) & 3) begin
                @(posedge sys_clk); #1;
            end
            ack = 1'b1;
            @(posedge sys_clk); #1;
            ack = 1'b0;
        end
        req = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    task automatic bad_req(input logic [2:0] b, input logic [3:0] c);
        chk("idle_before_bad", {31'd0, idle}, 32'd1);
        req = 1'b1; reads = 1'b0; ba = b; cnt = c; mws = 2'd3;
        @(posedge sys_clk); #1;
        req = 1'b0;
        push_done(1'b1, cyc);
        chk("bad_aen_done", {31'd0, aen}, 32'd0);
        @(posedge sys_clk); #1;
        chk("bad_aen_after", {31'd0, aen}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
        chk({tag, "_aen"},  {31'd0, aen},  32'd0);
        chk({tag, "_xa"},   {29'd0, xa},   32'd0);
        chk({tag, "_den"},  {24'd0, den},  32'd0);
        chk({tag, "_dmux"}, {29'd0, dmux}, 32'd0);
        chk({tag, "_dren"}, {31'd0, dren}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"},  {31'd0, err},  32'd0);
    endtask

    initial begin
        int t0;
        reset = 1'b1; req = 1'b0; reads = 1'b0; ba = '0; cnt = '0; mws = '0; ack = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_reset_outputs("rst");
        reset = 1'b0;
        @(posedge sys_clk); #1;

        // 64-bit memory, full word write
        push_cyc(3'd0, 8'hFF, 1'b0);
        xfer(1'b0, 3'd0, 4'd8, 2'd3, 1, 0, 1'b0);

        // byte memory read of lanes 2..4
        push_cyc(3'd2, 8'h04, 1'b1);
        push_cyc(3'd3, 8'h08, 1'b1);
        push_cyc(3'd4, 8'h10, 1'b1);
        xfer(1'b1, 3'd2, 4'd3, 2'd0, 3, 0, 1'b0);

        // 16-bit memory, unaligned start, waits and req noise while busy
        push_cyc(3'd2, 8'h08, 1'b0);
        push_cyc(3'd4, 8'h30, 1'b0);
        push_cyc(3'd6, 8'h40, 1'b0);
        xfer(1'b0, 3'd3, 4'd4, 2'd1, 3, 32'h21, 1'b1);

        // 32-bit memory read of lanes 1..6
        push_cyc(3'd0, 8'h0E, 1'b1);
        push_cyc(3'd4, 8'h70, 1'b1);
        xfer(1'b1, 3'd1, 4'd6, 2'd2, 2, 32'h4, 1'b0);

        // 64-bit memory, top three lanes
        push_cyc(3'd0, 8'hE0, 1'b1);
        xfer(1'b1, 3'd5, 4'd3, 2'd3, 1, 0, 1'b0);

        // 32-bit memory, aligned upper half
        push_cyc(3'd4, 8'hF0, 1'b0);
        xfer(1'b0, 3'd4, 4'd4, 2'd2, 1, 0, 1'b0);

        // last lane only
        push_cyc(3'd7, 8'h80, 1'b1);
        xfer(1'b1, 3'd7, 4'd1, 2'd0, 1, 0, 1'b0);

        // illegal requests
        bad_req(3'd6, 4'd4);
        bad_req(3'd0, 4'd0);

        // reset in the middle of a three-cycle transfer: no done expected
        push_cyc(3'd2, 8'h04, 1'b1);
        req = 1'b1; reads = 1'b1; ba = 3'd2; cnt = 4'd3; mws = 2'd0;
        @(posedge sys_clk); #1;
        req = 1'b0;
        @(posedge sys_clk); #1;
        ack = 1'b1;
        @(posedge sys_clk); #1;
        ack = 1'b0;
        @(posedge sys_clk); #1;
        chk("abort_in_cyc_aen", {31'd0, aen}, 32'd1);
        reset = 1'b1;
        @(posedge sys_clk); #1;
        reset = 1'b0;
        chk_reset_outputs("abort");
        repeat (4) @(posedge sys_clk);
        #1;

        // ack never arrives
        req = 1'b1; reads = 1'b0; ba = 3'd0; cnt = 4'd8; mws = 2'd3;
        @(posedge sys_clk); #1;
        req = 1'b0;
        t0 = cyc;
`ifdef BUS_ACK_TIMEOUT_EN
        push_done(1'b1, t0 + 256);
        repeat (258) @(posedge sys_clk);
        #1;
        chk("timeout_back_idle", {31'd0, idle}, 32'd1);
`else
        repeat (1000) @(posedge sys_clk);
        #1;
        chk("hang_aen", {31'd0, aen}, 32'd1);
        chk("hang_den", {24'd0, den}, 32'hFF);
        chk("hang_cycles", cyc - t0, 32'd1000);
        reset = 1'b1;
        @(posedge sys_clk); #1;
        reset = 1'b0;
        chk("hang_reset_idle", {31'd0, idle}, 32'd1);
`endif

        repeat (3) @(posedge sys_clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
